// File: rtl/ps2_kb_regs_if.sv
// Register-read bus between the memory controller (master) and the
// keyboard peripheral (slave).
interface ps2_kb_regs_if;
    logic        kb_read;
    logic [7:0]  kb_addr;
    logic [31:0] kb_rdata;

    modport master (output kb_read, output kb_addr, input kb_rdata);
    modport slave  (input kb_read, input kb_addr, output kb_rdata);
endinterface

// File: rtl/ps2_kb_regs.sv
// PS/2 keyboard receiver with E0/F0 prefix decode, key-event FIFO and read-only
// DATA/STATUS registers. Optional parity checking: define KB_PARITY_CHECK_EN.
module ps2_kb_regs #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic           clk,
    input  logic           rst,
    ps2_kb_regs_if.slave   kb,
    input  logic           ps2_clk,
    input  logic           ps2_data
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       fall;
    logic       rx_bit;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign rx_bit = data_sync[1];

    // ------------------------------------------------------------------
    // Receive state machine with idle timeout
    // ------------------------------------------------------------------
    rx_state_t       state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic [TW-1:0]   to_cnt;
    logic            to_expire;
`ifdef KB_PARITY_CHECK_EN
    logic            par_bit;
`endif

    // Expire on the cycle whose increment would reach TIMEOUT_CYCLES.
    assign to_expire = (state != ST_IDLE) && !fall &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            to_cnt  <= '0;
`ifdef KB_PARITY_CHECK_EN
            par_bit <= 1'b0;
`endif
        end else begin
            if (state == ST_IDLE || fall || to_expire) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (to_expire) begin
                state <= ST_IDLE;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_bit) begin
                            state   <= ST_SHIFT;
                            bit_cnt <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        shreg   <= {rx_bit, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
`ifdef KB_PARITY_CHECK_EN
                        par_bit <= rx_bit;
`endif
                        state   <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame acceptance and prefix decode
    // ------------------------------------------------------------------
    logic stop_ok;
    logic byte_done;
    logic parity_evt;
    logic is_e0;
    logic is_f0;
    logic push;
    logic ext;
    logic brk;

    assign stop_ok = (state == ST_STOP) && fall && rx_bit;

`ifdef KB_PARITY_CHECK_EN
    logic parity_ok;
    assign parity_ok  = ^{shreg, par_bit};
    assign byte_done  = stop_ok && parity_ok;
    assign parity_evt = stop_ok && !parity_ok;
`else
    assign byte_done  = stop_ok;
    assign parity_evt = 1'b0;
`endif

    assign is_e0 = (shreg == 8'hE0);
    assign is_f0 = (shreg == 8'hF0);
    assign push  = byte_done && !is_e0 && !is_f0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_done) begin
            if (is_e0) begin
                ext <= 1'b1;
            end else if (is_f0) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Key-event FIFO and sticky flags
    // ------------------------------------------------------------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic          ovf_evt;
    logic          status_rd;
    logic          overflow;
    logic          parity_err;
    logic [5:0]    word;
    logic [9:0]    head;
    logic [7:0]    count8;
    logic [31:0]   rdata;
    logic          unused_addr;

    assign word        = kb.kb_addr[7:2];
    assign unused_addr = &{1'b0, kb.kb_addr[1:0]};

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = kb.kb_read && (word == 6'd0) && !empty;
    assign status_rd = kb.kb_read && (word == 6'd1);
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign push_ok   = push && (!full || pop);
    assign ovf_evt   = push && full && !pop;

    // NOTE: the storage array has no reset; the count and pointers alone
    // define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {ext, brk, shreg};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow <= ovf_evt || (overflow && !status_rd);
        end
    end

`ifdef KB_PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_evt || (parity_err && !status_rd);
        end
    end
`else
    assign parity_err = parity_evt;
`endif

    // ------------------------------------------------------------------
    // Register read mux
    // ------------------------------------------------------------------
    assign head   = mem[rd_ptr];
    assign count8 = 8'(count);

    // NOTE: rdata gets a default before the case so no latch is inferred.
    always_comb begin
        rdata = '0;
        case (word)
            6'd0: begin
                if (!empty) begin
                    rdata = {1'b1, 21'd0, head};
                end
            end
            6'd1: begin
                rdata = {16'd0, count8, 4'd0, full, parity_err, overflow, !empty};
            end
            default: rdata = '0;
        endcase
    end

    assign kb.kb_rdata = rdata;

endmodule

// File: tb/tb_ps2_kb_regs.sv
// Self-checking bench for ps2_kb_regs: directed steps from the test plan,
// then random key streams against a queue-based reference model.
`timescale 1ns/1ps
module tb_ps2_kb_regs;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 5000;
    localparam int HALF    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_kb_regs_if kb_if ();

    ps2_kb_regs #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .kb       (kb_if),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a queue of {ext, brk, code} entries plus flags.
    logic [9:0] m_q[$];
    bit m_ext, m_brk, m_ovf, m_perr;

    task automatic model_reset();
        m_q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit bad);
`ifdef KB_PARITY_CHECK_EN
        if (bad) begin
            m_perr = 1;
            return;
        end
`endif
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (m_q.size() == DEPTH) m_ovf = 1;
            else m_q.push_back({m_ext, m_brk, b});
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    function automatic logic [31:0] exp_data();
        if (m_q.size() == 0) return 32'h0;
        return {1'b1, 21'd0, m_q[0]};
    endfunction

    function automatic logic [31:0] exp_status();
        logic [7:0] c;
        c = 8'(m_q.size());
        return {16'd0, c, 4'd0, (m_q.size() == DEPTH), m_perr, m_ovf, (m_q.size() != 0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [7:0] a, output logic [31:0] d);
        kb_if.kb_read = 1'b0;
        kb_if.kb_addr = a;
        #1 d = kb_if.kb_rdata;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        kb_if.kb_addr = a;
        kb_if.kb_read = 1'b1;
        #1 d = kb_if.kb_rdata;
        @(negedge clk);
        kb_if.kb_read = 1'b0;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad, b, 1'b0};
        send_bits(bits, 11);
        model_frame(b, bad);
    endtask

    // Read DATA (pops) and compare with the model head, then pop the model.
    task automatic pop_check(input string tag);
        logic [31:0] d;
        do_read(8'h00, d);
        check(tag, d, exp_data());
        if (m_q.size() != 0) void'(m_q.pop_front());
    endtask

    task automatic status_check(input string tag);
        logic [31:0] d;
        do_read(8'h04, d);
        check(tag, d, exp_status());
        m_ovf = 0;
        m_perr = 0;
    endtask

    function automatic logic [7:0] rand_code();
        logic [7:0] c;
        do c = 8'($urandom_range(0, 255)); while (c == 8'hE0 || c == 8'hF0);
        return c;
    endfunction

    initial begin
        logic [31:0] d;
        logic [7:0]  code;
        logic [7:0]  codes[$];

        kb_if.kb_read = 1'b0;
        kb_if.kb_addr = 8'h00;
        model_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        peek(8'h00, d); check("reset_data", d, 32'h0);
        peek(8'h04, d); check("reset_status", d, 32'h0);
        peek(8'h08, d); check("reset_addr08", d, 32'h0);
        peek(8'hFC, d); check("reset_addrFC", d, 32'h0);

        // Single frame
        send_frame(8'h1C, 0);
        peek(8'h00, d); check("frame1c_data", d, 32'h8000001C);
        peek(8'h04, d); check("frame1c_status", d, 32'h00000101);
        peek(8'h02, d); check("frame1c_addr_lsbs", d, 32'h8000001C);
        pop_check("frame1c_pop");
        peek(8'h04, d); check("frame1c_status_after", d, 32'h0);
        pop_check("empty_pop");
        peek(8'h04, d); check("empty_pop_status", d, 32'h0);

        // Prefix decode
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
        send_frame(8'h75, 0);
        peek(8'h00, d); check("prefix_data", d, 32'h80000375);
        pop_check("prefix_pop");
        peek(8'h00, d); check("noprefix_data", d, 32'h80000075);
        pop_check("noprefix_pop");

        // Overflow with 17 frames
        for (int i = 0; i < DEPTH + 1; i++) begin
            code = rand_code();
            codes.push_back(code);
            send_frame(code, 0);
        end
        peek(8'h04, d); check("ovf_status", d, 32'h0000100B);
        status_check("ovf_status_read");
        peek(8'h04, d); check("ovf_status_cleared", d, 32'h00001009);
        for (int i = 0; i < DEPTH; i++) begin
            peek(8'h00, d);
            check($sformatf("ovf_order_%0d", i), d, {24'h800000, codes[i]});
            pop_check($sformatf("ovf_pop_%0d", i));
        end
        peek(8'h00, d); check("ovf_17th_lost", d, 32'h0);

        // Bad parity
        send_frame(8'h1C, 1);
`ifdef KB_PARITY_CHECK_EN
        peek(8'h04, d); check("badpar_status", d, 32'h00000004);
        peek(8'h00, d); check("badpar_data", d, 32'h0);
        status_check("badpar_status_read");
`else
        peek(8'h00, d); check("badpar_data", d, 32'h8000001C);
        pop_check("badpar_pop");
`endif
        peek(8'h04, d); check("badpar_cleared", d, 32'h0);

        // Timeout: start bit + 3 data bits, then idle past the limit
        send_bits(11'b000_0000_1010, 4);
        repeat (TIMEOUT + 20) @(negedge clk);
        peek(8'h04, d); check("timeout_status", d, 32'h0);
        send_frame(8'h29, 0);
        peek(8'h00, d); check("timeout_recover", d, 32'h80000029);
        pop_check("timeout_pop");

        // Random key streams against the model
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) send_frame(8'hE0, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) send_frame(8'hF0, $urandom_range(0, 15) == 0);
            send_frame(rand_code(), $urandom_range(0, 9) == 0);
            peek(8'h00, d); check($sformatf("rnd_data_%0d", it), d, exp_data());
            peek(8'h04, d); check($sformatf("rnd_status_%0d", it), d, exp_status());
            if ($urandom_range(0, 2) == 0) pop_check($sformatf("rnd_pop_%0d", it));
            if ($urandom_range(0, 4) == 0) status_check($sformatf("rnd_stat_rd_%0d", it));
        end
        while (m_q.size() != 0) pop_check("drain_pop");
        status_check("drain_status");
        peek(8'h04, d); check("drain_final_status", d, 32'h0);

        // Asynchronous reset with entries queued and a frame in flight
        send_frame(8'h11, 0);
        send_frame(8'h22, 0);
        send_bits(11'b000_0000_0110, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        peek(8'h00, d); check("async_rst_data", d, 32'h0);
        peek(8'h04, d); check("async_rst_status", d, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_frame(8'h33, 0);
        peek(8'h00, d); check("post_rst_frame", d, 32'h80000033);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
